// File: rtl/ts_rec_pkg.sv
// Shared types and constants for the TS recorder mode controller.
package ts_rec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2,
      ST_PAUSE  = 2'd3
   } state_t;

   // Bit positions of the button-release pulses on RELEASE
   localparam int BTN_REC   = 0;
   localparam int BTN_PLAY  = 1;
   localparam int BTN_STOP  = 2;
   localparam int BTN_PAUSE = 3;

endpackage

// File: rtl/ts_rec_addr_cnt.sv
// Packet-store address counter: synchronous clear (wins over enable),
// increment on enable, wraps modulo 2**ADDR_W.
module ts_rec_addr_cnt #(
   parameter int ADDR_W = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CLR,
   input  logic              EN,
   output logic [ADDR_W-1:0] ADDR
);

   logic [ADDR_W-1:0] addr_reg;

   // Address register: reset/clear to zero, otherwise count packets
   always_ff @(posedge CLOCK) begin
      if (RESET || CLR)
         addr_reg <= '0;
      else if (EN)
         addr_reg <= addr_reg + ADDR_W'(1);
   end

   assign ADDR = addr_reg;

endmodule

// File: rtl/ts_rec_mode_ctrl.sv
// Recorder mode controller: sequences IDLE/RECORD/PLAY/PAUSE from button
// release pulses, owns write/read addresses, recorded length, FULL and
// PLAY_DONE. Optional build macro TS_REC_LOOP_EN makes playback loop
// instead of returning to IDLE at the end of the recording.
module ts_rec_mode_ctrl
   import ts_rec_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [3:0]        RELEASE,
   input  logic              WR_PKT,
   input  logic              RD_PKT,
   output logic              REC_EN,
   output logic              PLAY_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [ADDR_W-1:0] RD_ADDR,
   output logic [ADDR_W:0]   REC_LEN,
   output logic [1:0]        STATE,
   output logic              FULL,
   output logic              PLAY_DONE
);

   localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_reg, state_next;
   state_t            resume_reg, resume_next;
   logic [ADDR_W:0]   rec_len_reg, rec_len_next;
   logic              full_reg, full_next;
   logic              done_reg, done_next;
   logic              wr_clr, wr_en, rd_clr, rd_en;
   logic              cmd_stop, cmd_pause, cmd_rec, cmd_play;
   logic [ADDR_W:0]   len_inc;
   logic [ADDR_W:0]   rd_inc;
   logic              play_end;

   // Fixed command priority: STOP > PAUSE > REC > PLAY, lower pulses dropped
   assign cmd_stop  = RELEASE[BTN_STOP];
   assign cmd_pause = RELEASE[BTN_PAUSE] && !cmd_stop;
   assign cmd_rec   = RELEASE[BTN_REC]   && !cmd_stop && !RELEASE[BTN_PAUSE];
   assign cmd_play  = RELEASE[BTN_PLAY]  && !cmd_stop && !RELEASE[BTN_PAUSE] && !RELEASE[BTN_REC];

   assign len_inc  = rec_len_reg + (ADDR_W+1)'(1);
   assign rd_inc   = {1'b0, RD_ADDR} + (ADDR_W+1)'(1);
   assign play_end = RD_PKT && (rd_inc == rec_len_reg);

   ts_rec_addr_cnt #(.ADDR_W(ADDR_W)) u_wr_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .CLR   (wr_clr),
      .EN    (wr_en),
      .ADDR  (WR_ADDR)
   );

   ts_rec_addr_cnt #(.ADDR_W(ADDR_W)) u_rd_cnt (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .CLR   (rd_clr),
      .EN    (rd_en),
      .ADDR  (RD_ADDR)
   );

   // State, resume target, recorded length and status flag registers
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_reg   <= ST_IDLE;
         resume_reg  <= ST_RECORD;
         rec_len_reg <= '0;
         full_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         resume_reg  <= resume_next;
         rec_len_reg <= rec_len_next;
         full_reg    <= full_next;
         done_reg    <= done_next;
      end
   end

   // Next-state decode: packet counting uses the current state, the
   // transition is then applied on the same edge
   always_comb begin
      state_next   = state_reg;
      resume_next  = resume_reg;
      rec_len_next = rec_len_reg;
      full_next    = full_reg;
      done_next    = 1'b0;
      wr_clr       = 1'b0;
      wr_en        = 1'b0;
      rd_clr       = 1'b0;
      rd_en        = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (cmd_rec) begin
               state_next   = ST_RECORD;
               wr_clr       = 1'b1;
               rec_len_next = '0;
               full_next    = 1'b0;
            end else if (cmd_play && (rec_len_reg != '0)) begin
               state_next = ST_PLAY;
               rd_clr     = 1'b1;
            end
         end
         ST_RECORD: begin
            if (WR_PKT && (rec_len_reg != CAPACITY)) begin
               wr_en        = 1'b1;
               rec_len_next = len_inc;
            end
            // Hitting capacity ends the recording even if STOP/PAUSE arrive too
            if (WR_PKT && (len_inc == CAPACITY)) begin
               state_next = ST_IDLE;
               full_next  = 1'b1;
            end else if (cmd_stop) begin
               state_next = ST_IDLE;
            end else if (cmd_pause) begin
               state_next  = ST_PAUSE;
               resume_next = ST_RECORD;
            end
         end
         ST_PLAY: begin
            rd_en = RD_PKT;
`ifdef TS_REC_LOOP_EN
            // Wrap to the start of the recording and keep playing
            if (play_end) begin
               done_next = 1'b1;
               rd_clr    = 1'b1;
            end
            if (cmd_stop) begin
               state_next = ST_IDLE;
            end else if (cmd_pause) begin
               state_next  = ST_PAUSE;
               resume_next = ST_PLAY;
            end
`else
            if (play_end) begin
               done_next  = 1'b1;
               state_next = ST_IDLE;
            end else if (cmd_stop) begin
               state_next = ST_IDLE;
            end else if (cmd_pause) begin
               state_next  = ST_PAUSE;
               resume_next = ST_PLAY;
            end
`endif
         end
         ST_PAUSE: begin
            if (cmd_stop)
               state_next = ST_IDLE;
            else if (cmd_pause)
               state_next = resume_reg;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign REC_EN    = (state_reg == ST_RECORD);
   assign PLAY_EN   = (state_reg == ST_PLAY);
   assign STATE     = state_reg;
   assign REC_LEN   = rec_len_reg;
   assign FULL      = full_reg;
   assign PLAY_DONE = done_reg;

endmodule

// File: tb/tb_ts_rec_mode_ctrl.sv
// Scoreboard bench for ts_rec_mode_ctrl (ADDR_W=4). Stimulus pushes the
// hand-computed expected outputs after each checked edge; a monitor pops
// them on the falling edge and compares. Honors TS_REC_LOOP_EN.
module tb_ts_rec_mode_ctrl;

   localparam int AW = 4;

   logic          CLOCK = 1'b0;
   logic          RESET = 1'b1;
   logic [3:0]    RELEASE = 4'b0;
   logic          WR_PKT = 1'b0;
   logic          RD_PKT = 1'b0;
   logic          REC_EN, PLAY_EN, FULL, PLAY_DONE;
   logic [AW-1:0] WR_ADDR, RD_ADDR;
   logic [AW:0]   REC_LEN;
   logic [1:0]    STATE;

   typedef struct {
      string name;
      int    st;
      int    len;
      int    wa;
      int    ra;
      int    full;
      int    done;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [3:0] R_REC   = 4'b0001;
   localparam logic [3:0] R_PLAY  = 4'b0010;
   localparam logic [3:0] R_STOP  = 4'b0100;
   localparam logic [3:0] R_PAUSE = 4'b1000;

   ts_rec_mode_ctrl #(.ADDR_W(AW)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .RELEASE   (RELEASE),
      .WR_PKT    (WR_PKT),
      .RD_PKT    (RD_PKT),
      .REC_EN    (REC_EN),
      .PLAY_EN   (PLAY_EN),
      .WR_ADDR   (WR_ADDR),
      .RD_ADDR   (RD_ADDR),
      .REC_LEN   (REC_LEN),
      .STATE     (STATE),
      .FULL      (FULL),
      .PLAY_DONE (PLAY_DONE)
   );

   always #5 CLOCK = ~CLOCK;

   // One clock with the given inputs; inputs return to idle afterwards
   task automatic cyc(input logic [3:0] rel, input logic wr, input logic rd);
      RELEASE = rel;
      WR_PKT  = wr;
      RD_PKT  = rd;
      @(posedge CLOCK);
      #1;
      RELEASE = 4'b0;
      WR_PKT  = 1'b0;
      RD_PKT  = 1'b0;
   endtask

   task automatic expect_out(input string n, input int st, input int len, input int wa,
                             input int ra, input int full, input int done);
      exp_t e;
      e.name = n; e.st = st; e.len = len; e.wa = wa; e.ra = ra; e.full = full; e.done = done;
      sb.push_back(e);
   endtask

   task automatic cmp(input string n, input string f, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s.%s: got %0d, expected %0d", n, f, act, exp);
      end
   endtask

   // Monitor: compare every pending expectation on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            cmp(e.name, "STATE",     int'(STATE),     e.st);
            cmp(e.name, "REC_EN",    int'(REC_EN),    (e.st == 1) ? 1 : 0);
            cmp(e.name, "PLAY_EN",   int'(PLAY_EN),   (e.st == 2) ? 1 : 0);
            cmp(e.name, "REC_LEN",   int'(REC_LEN),   e.len);
            cmp(e.name, "WR_ADDR",   int'(WR_ADDR),   e.wa);
            cmp(e.name, "RD_ADDR",   int'(RD_ADDR),   e.ra);
            cmp(e.name, "FULL",      int'(FULL),      e.full);
            cmp(e.name, "PLAY_DONE", int'(PLAY_DONE), e.done);
            $display("check %s: state=%0d len=%0d wa=%0d ra=%0d full=%0d done=%0d",
                     e.name, STATE, REC_LEN, WR_ADDR, RD_ADDR, FULL, PLAY_DONE);
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset
      cyc(4'b0, 1'b0, 1'b0);
      cyc(4'b0, 1'b0, 1'b0);
      expect_out("reset", 0, 0, 0, 0, 0, 0);
      RESET = 1'b0;

      // Reset mid-RECORD discards the recording
      cyc(R_REC, 1'b0, 1'b0);
      expect_out("rec_start", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(4'b0, 1'b1, 1'b0);
      expect_out("rec_5", 1, 5, 5, 0, 0, 0);
      RESET = 1'b1;
      cyc(4'b0, 1'b1, 1'b0);
      RESET = 1'b0;
      expect_out("reset_mid", 0, 0, 0, 0, 0, 0);

      // Record 3, stop, play back 3
      cyc(R_REC, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(4'b0, 1'b1, 1'b0);
      expect_out("rec_3", 1, 3, 3, 0, 0, 0);
      cyc(R_STOP, 1'b0, 1'b0);
      expect_out("stop_rec", 0, 3, 3, 0, 0, 0);
      cyc(R_PLAY, 1'b0, 1'b0);
      expect_out("play_start", 2, 3, 3, 0, 0, 0);
      cyc(4'b0, 1'b0, 1'b1);
      cyc(4'b0, 1'b0, 1'b1);
      expect_out("play_2", 2, 3, 3, 2, 0, 0);
      cyc(4'b0, 1'b0, 1'b1);
`ifdef TS_REC_LOOP_EN
      expect_out("play_end", 2, 3, 3, 0, 0, 1);
      cyc(4'b0, 1'b0, 1'b0);
      expect_out("play_after", 2, 3, 3, 0, 0, 0);
      cyc(R_STOP, 1'b0, 1'b0);
      expect_out("play_stop", 0, 3, 3, 0, 0, 0);
`else
      expect_out("play_end", 0, 3, 3, 3, 0, 1);
      cyc(4'b0, 1'b0, 1'b0);
      expect_out("play_after", 0, 3, 3, 3, 0, 0);
`endif

      // Fill to capacity; last write coincides with STOP, FULL still set
      cyc(R_REC, 1'b0, 1'b0);
      expect_out("rec_again", 1, 0, 0, 3 * 0 + int'(RD_ADDR), 0, 0);
      for (int i = 0; i < 15; i++) cyc(4'b0, 1'b1, 1'b0);
      expect_out("rec_15", 1, 15, 15, int'(RD_ADDR), 0, 0);
      cyc(R_STOP, 1'b1, 1'b0);
      expect_out("rec_full", 0, 16, 0, int'(RD_ADDR), 1, 0);
      cyc(R_REC, 1'b0, 1'b0);
      expect_out("full_clr", 1, 0, 0, int'(RD_ADDR), 0, 0);

      // Pause during RECORD freezes the write counter
      cyc(4'b0, 1'b1, 1'b0);
      cyc(4'b0, 1'b1, 1'b0);
      cyc(R_PAUSE, 1'b0, 1'b0);
      expect_out("rec_pause", 3, 2, 2, int'(RD_ADDR), 0, 0);
      cyc(4'b0, 1'b1, 1'b0);
      cyc(4'b0, 1'b1, 1'b0);
      expect_out("rec_paused_wr", 3, 2, 2, int'(RD_ADDR), 0, 0);
      cyc(R_PAUSE, 1'b0, 1'b0);
      expect_out("rec_resume", 1, 2, 2, int'(RD_ADDR), 0, 0);
      for (int i = 0; i < 3; i++) cyc(4'b0, 1'b1, 1'b0);
      cyc(R_STOP, 1'b0, 1'b0);
      expect_out("rec_5_stop", 0, 5, 5, int'(RD_ADDR), 0, 0);

      // Playback with pause: read counter frozen while paused
      cyc(R_PLAY, 1'b0, 1'b0);
      expect_out("play2_start", 2, 5, 5, 0, 0, 0);
      cyc(4'b0, 1'b0, 1'b1);
      cyc(4'b0, 1'b0, 1'b1);
      cyc(R_PAUSE, 1'b0, 1'b0);
      expect_out("play_pause", 3, 5, 5, 2, 0, 0);
      for (int i = 0; i < 4; i++) cyc(4'b0, 1'b0, 1'b1);
      expect_out("play_paused_rd", 3, 5, 5, 2, 0, 0);
      cyc(R_PAUSE, 1'b0, 1'b0);
      expect_out("play_resume", 2, 5, 5, 2, 0, 0);
      cyc(4'b0, 1'b0, 1'b1);
      expect_out("play_ra3", 2, 5, 5, 3, 0, 0);
      cyc(R_STOP, 1'b0, 1'b0);
      expect_out("play2_stop", 0, 5, 5, 3, 0, 0);

      // Simultaneous pulses
      cyc(R_REC, 1'b0, 1'b0);
      expect_out("rec3_start", 1, 0, 0, 3, 0, 0);
      cyc(4'b1111, 1'b0, 1'b0);
      expect_out("all_btn_rec", 0, 0, 0, 3, 0, 0);
      cyc(4'b0011, 1'b0, 1'b0);
      expect_out("rec_over_play", 1, 0, 0, 3, 0, 0);
      cyc(R_STOP, 1'b0, 1'b0);
      expect_out("empty_stop", 0, 0, 0, 3, 0, 0);

      // Idle ignores PLAY with empty recording and stray packets
      cyc(R_PLAY, 1'b0, 1'b0);
      expect_out("play_empty", 0, 0, 0, 3, 0, 0);
      cyc(4'b0, 1'b1, 1'b1);
      expect_out("idle_pkts", 0, 0, 0, 3, 0, 0);
      cyc(R_PAUSE, 1'b0, 1'b0);
      expect_out("idle_pause", 0, 0, 0, 3, 0, 0);

      // Drain the scoreboard
      repeat (3) @(posedge CLOCK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
